// File: rtl/serial_parity_checker_pkg.sv
// Shared types for the serial parity receiver: FSM states and parity-sense
// encodings used by the accumulator.
package serial_parity_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam bit PAR_EVEN = 1'b0;
  localparam bit PAR_ODD  = 1'b1;

endpackage

// File: rtl/parity_accum.sv
// Running XOR of a frame's data bits plus the final parity compare
// (XOR for even sense, XNOR for odd sense).
module parity_accum
  import serial_parity_pkg::*;
#(
  parameter bit SENSE = PAR_EVEN
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic load,
  input  logic upd,
  input  logic din,
  output logic acc,
  output logic err
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       acc <= 1'b0;
    else if (clr)  acc <= 1'b0;
    else if (load) acc <= din;
    else if (upd)  acc <= acc ^ din;
  end

  // din here is the parity bit; err is only captured in the PARITY state
  assign err = ((acc ^ din) != SENSE);

endmodule

// File: rtl/serial_parity_checker.sv
// Serial parity receiver: deserialises DATA_BITS LSB-first plus one parity
// bit and presents the word and error flag on a valid/ready output.
module serial_parity_checker
  import serial_parity_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int ODD_PARITY = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 din,
  input  logic                 din_valid,
  input  logic                 start,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 parity_err,
  output logic                 busy,
  output logic                 overrun
);

  localparam int CW = $clog2(DATA_BITS + 1);
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t   LAST       = CW'(DATA_BITS - 1);
  localparam state_t FIRST_NEXT = (DATA_BITS == 1) ? PARITY : DATA;

  state_t state, state_n;
  cnt_t   cnt;
  logic   ld_first, shift, err_cap, ovr_set, hs;
  logic   acc, acc_err;

  parity_accum #(
    .SENSE (ODD_PARITY != 0 ? PAR_ODD : PAR_EVEN)
  ) u_acc (
    .clk  (clk),
    .rst  (rst),
    .clr  (hs),
    .load (ld_first),
    .upd  (shift),
    .din  (din),
    .acc  (acc),
    .err  (acc_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    ld_first = 1'b0;
    shift    = 1'b0;
    err_cap  = 1'b0;
    ovr_set  = 1'b0;
    hs       = 1'b0;
    unique case (state)
      IDLE: begin
        if (din_valid && start) begin
          ld_first = 1'b1;
          state_n  = FIRST_NEXT;
        end
      end
      DATA: begin
        if (din_valid && start) begin
          ld_first = 1'b1;
          state_n  = FIRST_NEXT;
        end else if (din_valid) begin
          shift = 1'b1;
          if (cnt == LAST) state_n = PARITY;
        end
      end
      PARITY: begin
        if (din_valid && start) begin
          ld_first = 1'b1;
          state_n  = FIRST_NEXT;
        end else if (din_valid) begin
          err_cap = 1'b1;
          state_n = HOLD;
        end
      end
      HOLD: begin
        // every din is dropped here; a start bit is flagged as an overrun
        ovr_set = din_valid && start;
        if (out_ready) begin
          hs      = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out <= '0;
      cnt      <= '0;
    end else if (ld_first) begin
      data_out <= DATA_BITS'(din);
      cnt      <= CW'(1);
    end else if (shift) begin
      for (int i = 0; i < DATA_BITS; i++)
        if (cnt == CW'(i)) data_out[i] <= din;
      cnt <= cnt + CW'(1);
    end else if (hs) begin
      cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= ovr_set;
      if (err_cap) parity_err <= acc_err;
    end
  end

  assign out_valid = (state == HOLD);
  assign busy      = (state == DATA) || (state == PARITY);

endmodule

// File: tb/tb_serial_parity_checker.sv
// Directed bench for serial_parity_checker: even and odd instances share the
// serial stimulus; a monitor pops expected words on every output handshake.
module tb_serial_parity_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din = 1'b0, din_valid = 1'b0, start = 1'b0, out_ready = 1'b1;
  logic [7:0] ev_data, od_data;
  logic       ev_valid, od_valid, ev_err, od_err, ev_busy, od_busy, ev_ovr, od_ovr;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0] data;
    logic       err;
  } exp_t;
  exp_t q_ev[$];
  exp_t q_od[$];

  always #5 clk = ~clk;

  serial_parity_checker #(.DATA_BITS(8), .ODD_PARITY(0)) u_even (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .start(start),
    .data_out(ev_data), .out_valid(ev_valid), .out_ready(out_ready),
    .parity_err(ev_err), .busy(ev_busy), .overrun(ev_ovr)
  );

  serial_parity_checker #(.DATA_BITS(8), .ODD_PARITY(1)) u_odd (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .start(start),
    .data_out(od_data), .out_valid(od_valid), .out_ready(out_ready),
    .parity_err(od_err), .busy(od_busy), .overrun(od_ovr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (!rst && ev_valid && out_ready) begin
      if (q_ev.size() == 0) begin
        tests++; fails++;
        $display("FAIL even_unexpected: got data %0h expected no output", ev_data);
      end else begin
        e = q_ev.pop_front();
        chk("even_data", ev_data, e.data);
        chk("even_err", ev_err, e.err);
      end
    end
    if (!rst && od_valid && out_ready) begin
      if (q_od.size() == 0) begin
        tests++; fails++;
        $display("FAIL odd_unexpected: got data %0h expected no output", od_data);
      end else begin
        e = q_od.pop_front();
        chk("odd_data", od_data, e.data);
        chk("odd_err", od_err, e.err);
      end
    end
  end

  // all drive tasks start and end at posedge+1
  task automatic drive(input logic b, input logic st, input int gap, input bit chk_busy);
    din_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); #1;
      if (chk_busy) chk("busy_gap", {ev_busy, od_busy}, 2'b11);
    end
    din = b; din_valid = 1'b1; start = st;
    @(posedge clk); #1;
    din_valid = 1'b0; start = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input int maxgap,
                            input logic ee, input logic oe);
    q_ev.push_back('{data: d, err: ee});
    q_od.push_back('{data: d, err: oe});
    for (int i = 0; i < 8; i++) begin
      drive(d[i], i == 0, int'($urandom_range(maxgap, 0)), i != 0);
      chk("busy_data", {ev_busy, od_busy}, 2'b11);
    end
    drive(p, 1'b0, int'($urandom_range(maxgap, 0)), 1'b1);
    chk("valid_latency", {ev_valid, od_valid}, 2'b11);
    chk("busy_hold", {ev_busy, od_busy}, 2'b00);
  endtask

  task automatic wait_release();
    bit done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (!ev_valid && !od_valid) done = 1;
      else begin @(posedge clk); #1; end
    end
    if (!done) begin
      tests++; fails++;
      $display("FAIL release_timeout: got out_valid still high expected low within 20 cycles");
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100us");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk); #1;
    chk("rst_data", {ev_data, od_data}, 16'h0);
    chk("rst_flags", {ev_valid, od_valid, ev_err, od_err, ev_busy, od_busy, ev_ovr, od_ovr}, 8'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 0xA5 has four ones
    send_frame(8'hA5, 1'b0, 0, 1'b0, 1'b1); wait_release();
    send_frame(8'hA5, 1'b1, 0, 1'b1, 1'b0); wait_release();
    // 0x07 has three ones
    send_frame(8'h07, 1'b0, 0, 1'b1, 1'b0); wait_release();
    send_frame(8'h07, 1'b1, 0, 1'b0, 1'b1); wait_release();
    // gapped frame
    send_frame(8'h3C, 1'b0, 3, 1'b0, 1'b1); wait_release();

    // backpressure with a start bit arriving in HOLD
    out_ready = 1'b0;
    send_frame(8'h5A, 1'b0, 0, 1'b0, 1'b1);
    repeat (2) begin @(posedge clk); #1; end
    drive(1'b1, 1'b1, 0, 1'b0);
    chk("overrun_pulse", {ev_ovr, od_ovr}, 2'b11);
    chk("hold_valid", {ev_valid, od_valid}, 2'b11);
    chk("hold_no_frame", {ev_busy, od_busy}, 2'b00);
    chk("hold_data", {ev_data, od_data}, 16'h5A5A);
    @(posedge clk); #1;
    chk("overrun_clear", {ev_ovr, od_ovr}, 2'b00);
    chk("hold_data2", {ev_data, od_data}, 16'h5A5A);
    out_ready = 1'b1;
    @(posedge clk); #1;
    wait_release();
    chk("after_hs_idle", {ev_busy, od_busy, ev_ovr, od_ovr}, 4'h0);

    // resync after four bits, then a full 0x81
    drive(1'b1, 1'b1, 0, 1'b0);
    drive(1'b1, 1'b0, 0, 1'b0);
    drive(1'b0, 1'b0, 0, 1'b0);
    drive(1'b1, 1'b0, 0, 1'b0);
    send_frame(8'h81, 1'b0, 0, 1'b0, 1'b1); wait_release();

    // async reset mid-frame
    drive(1'b1, 1'b1, 0, 1'b0);
    drive(1'b1, 1'b0, 0, 1'b0);
    drive(1'b1, 1'b0, 0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("midrst_data", {ev_data, od_data}, 16'h0);
    chk("midrst_flags", {ev_valid, od_valid, ev_err, od_err, ev_busy, od_busy, ev_ovr, od_ovr}, 8'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    // 0x0F has four ones
    send_frame(8'h0F, 1'b1, 0, 1'b1, 1'b0); wait_release();

    repeat (3) @(posedge clk); #1;
    chk("queue_even_empty", q_ev.size(), 0);
    chk("queue_odd_empty", q_od.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
